// File: rtl/uart_tx_responder_if.sv
// rtl/uart_tx_responder_if.sv - byte-send handshake between the result streamer and the UART transmitter
interface uart_tx_responder_if;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_rdy;

    modport master (output tx_data, output tx_en, input tx_rdy);
    modport slave  (input tx_data, input tx_en, output tx_rdy);
endinterface

// File: rtl/uart_tx_responder.sv
// rtl/uart_tx_responder.sv - FIFO-buffered 8N1 UART transmitter, LSB first
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_responder #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_responder_if.slave          bus,
    output logic                        txd,
    output logic                        tx_busy,
    output logic [7:0]                  tx_last,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          LW        = AW + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    state_t          state_next;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [15:0]     baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            push;
    logic            pop;
    logic            baud_wrap;
    logic            txd_next;
    logic [LW-1:0]   level_next;
`ifdef UART_TX_PARITY_EN
    logic            parity;
`endif

    assign push      = bus.tx_en && bus.tx_rdy;
    assign baud_wrap = (baud_cnt == BAUD_LAST);
    assign tx_busy   = (state != IDLE) || (fifo_level != '0);

    // tx_rdy is registered from the post-edge level, so a push at full is refused even with a pop
    always_comb begin
        level_next = fifo_level;
        if (push && !pop) begin
            level_next = fifo_level + LW'(1);
        end else if (!push && pop) begin
            level_next = fifo_level - LW'(1);
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        txd_next   = 1'b1;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                txd_next = 1'b0;
                if (baud_wrap) state_next = DATA;
            end
            DATA: begin
                txd_next = shift[0];
                if (baud_wrap && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd_next = parity;
                if (baud_wrap) state_next = STOP;
            end
`endif
            STOP: begin
                if (baud_wrap) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // txd is registered from the current state, so the line lags the FSM by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            txd        <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            bus.tx_rdy <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            tx_last    <= '0;
`ifdef UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            txd        <= txd_next;
            fifo_level <= level_next;
            bus.tx_rdy <= (level_next < LW'(FIFO_DEPTH));
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                shift   <= mem[rd_ptr];
                tx_last <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                parity  <= ^mem[rd_ptr];
`endif
            end
            if (state == IDLE || baud_wrap) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && baud_wrap) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.tx_data;
    end
endmodule

// File: doc/uart_tx_responder.md
Name: uart_tx_responder

Overview:
- Transmit end of the controller's byte-send handshake (tx_data / tx_en / tx_rdy).
- Accepts bytes, buffers them in a small FIFO, and serializes each one onto the UART TXD line as 8N1, LSB first.
- Sits between the result-streaming state machine and the board UART pin; also drives the transmit-data LED mirror.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock (PLL output).
- reset  in  1  synchronous, active-high.
- tx_data  in  8  byte to send; sampled on an accept cycle.
- tx_en  in  1  push request; a byte is accepted when tx_en && tx_rdy at a clk edge.
- tx_rdy  out  1  registered; 1 when the FIFO can accept a byte.
- txd  out  1  UART serial output; idle high.
- tx_busy  out  1  1 while a frame is on the line or the FIFO is non-empty.
- tx_last  out  8  last byte that began transmission (LED mirror).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of bytes buffered, excluding the byte being shifted out.

Behaviour:
- Reset values: txd=1, tx_rdy=0, tx_busy=0, tx_last=0, fifo_level=0. FIFO pointers, bit counter, and baud counter are cleared. The state machine goes to IDLE.
- tx_rdy rises the first cycle after reset deasserts.
- Reset mid-frame aborts the frame: txd=1 on the next edge and buffered bytes are discarded.
- tx_rdy is registered and equals (next fifo_level < FIFO_DEPTH).
- tx_en while tx_rdy=0 is ignored; no byte is lost or stored, and the sender must hold and retry.
- The sender may pulse tx_en for a single cycle; that is sufficient when tx_rdy=1.
- Push and pop in the same cycle: fifo_level is unchanged. A push at full with a simultaneous pop is still refused, because tx_rdy was already 0.
- State machine IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: txd=1. If fifo_level>0, pop the head into the shift register, set tx_last to that byte, and go to START.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, shifting right, 8 bits, bit index 0..7.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
- Latency: a byte pushed into an empty, idle block drives txd low on the 2nd edge after the accept edge (accept, then IDLE pop, then START).
- Frame length is 10*CLKS_PER_BIT cycles. Back-to-back frames are spaced exactly 10*CLKS_PER_BIT+1 cycles start-to-start (one IDLE cycle).
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. Bit transitions occur only at wrap.
- FIFO pointers wrap modulo FIFO_DEPTH; a separate occupancy count distinguishes full from empty.
- tx_busy = (state != IDLE) || (fifo_level != 0).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted as a PARITY state between DATA and STOP, lasting CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT cycles and start-to-start spacing becomes 11*CLKS_PER_BIT+1 cycles.
- Undefined: 8N1 framing exactly as in Behaviour, with no parity logic present.

Test Plan:
- Reset-state check, CLKS_PER_BIT=4: hold reset 3 cycles -> txd=1, tx_rdy=0, fifo_level=0 during reset; tx_rdy=1 one cycle after release.
- Single byte 0xA5, one-cycle tx_en pulse -> txd low 2 edges later; bit pattern 0,1,0,1,0,0,1,0,1,1, each 4 cycles; tx_last=0xA5; tx_busy falls after the stop bit.
- Five-byte burst 0x12,0x34,0x56,0x78,0x9A pushed whenever tx_rdy=1, FIFO_DEPTH=4 -> tx_rdy drops when the FIFO reaches 4; all 5 bytes appear in order; start bits spaced 41 cycles apart.
- Push at full: hold tx_en=1 with 0xFF while tx_rdy=0 -> fifo_level stays 4; 0xFF is accepted only on the first cycle tx_rdy=1 and is transmitted exactly once.
- Reset mid-frame after bit 3 of 0x0F with 2 bytes queued -> txd=1 the next cycle; fifo_level=0; no further frames are sent.
- UART_TX_PARITY_EN defined, byte 0x07 -> parity bit=1 between bit 7 and stop; frame is 44 cycles.
